rom_fsm_seq: RTL and testbench
==============================

// Module: rom_fsm_seq
// PURPOSE
//  Table-driven finite state machine. A writable transition table, indexed by
//  {state, in}, supplies the next state and the output word.
//  Parametrised successor of the fixed 3-bit ROM sequencer, adding:
//  - input-dependent transitions
//  - Mealy or registered-output mode
//  - step enable
//  - run-time table programming
//  - illegal-entry detection and recovery
//  Used by the lab sequencer/counter datapaths as a reprogrammable controller.
// PARAMETERS
//  STATE_W    3    state register width; 2**STATE_W states
//  IN_W       1    input vector width; table depth = 2**(STATE_W+IN_W)
//  OUT_W      3    output word width
//  INIT_STATE 0    state loaded on reset and on illegal-entry recovery
//  REG_OUT    0    0 = Mealy (out combinational from table); 1 = out registered
//  INIT_FILE  ""   if non-empty, table preloaded with $readmemh at elaboration
// PORTS
//  clk      in   1                   rising-edge clock
//  reset    in   1                   asynchronous, active-low reset
//  en       in   1                   step enable: state advances only when 1
//  in       in   IN_W                FSM input, sampled with state
//  wr_en    in   1                   table write strobe
//  wr_addr  in   STATE_W+IN_W        table entry index {state,in}
//  wr_data  in   1+STATE_W+OUT_W     entry {valid, next_state, out}
//  out      out  OUT_W               FSM output word
//  state    out  STATE_W             current state
//  illegal  out  1                   1-cycle pulse: stepped on an invalid entry
//  err_cnt  out  8                   saturating count of illegal events
// BEHAVIOUR
//  - Entry format: [MSB] valid, then next_state[STATE_W], then out[OUT_W] in the LSBs.
//  - Address: addr = {state, in}. Table read is combinational (asynchronous).
//  - Reset (reset==0, async), all of the following:
//    - state = INIT_STATE
//    - out register = 0
//    - illegal = 0
//    - err_cnt = 0
//    - the table is NOT cleared.
//  - Step (rising clk, en==1):
//    - valid entry: state <= entry.next_state.
//    - invalid entry: state <= INIT_STATE, illegal <= 1 for one cycle,
//      err_cnt <= err_cnt+1, saturating at 255.
//  - en==0: state, out register and err_cnt hold; illegal <= 0.
//  - REG_OUT=0: out = entry.valid ? entry.out : 0. Combinational with 0-cycle
//    latency from state/in; changes with in regardless of en.
//  - REG_OUT=1: on an en step, out <= entry.valid ? entry.out : 0. One cycle of
//    latency, aligned with the new state; holds when en==0.
//  - Table write:
//    - wr_en==1 writes wr_data to wr_addr at the rising clk.
//    - A same-cycle step reading the same address uses the OLD entry (read-before-write).
//    - The new entry is visible from the next cycle.
//  - Writes are permitted during reset assertion and mid-run; no stall is generated.
//  - Without INIT_FILE, table contents before the first write are X. The bench
//    must program every reachable entry before deasserting reset.
//  - Wrap-around: next_state is a plain STATE_W field, so any code is reachable.
//    No arithmetic is performed on state.
//  - Reset mid-step: async reset wins over a coincident en step or illegal event.
//    A coincident wr_en write is still performed.
// TESTING
//  1 STATE_W=3,IN_W=0 (degenerate index), REG_OUT=0. Program
//    0->1/0, 1->3/1, 3->5/3, 5->7/5, 7->2/7, 2->0/2; en=1 ->
//    state 0,1,3,5,7,2,0 and out 0,1,3,5,7,2 on successive cycles.
//  2 IN_W=1, 2-state toggle FSM: entries {0,0}->0/0, {0,1}->1/1, {1,0}->1/0,
//    {1,1}->0/1; drive in=1,1,0,1 -> state 1,0,0,1; out tracks in the same cycle.
//  3 Leave entry 4 invalid, step into state 4 -> next cycle state=INIT_STATE,
//    illegal=1 for exactly 1 cycle, err_cnt=1; repeat 300 times -> err_cnt=255.
//  4 REG_OUT=1 with the scenario-1 table -> out lags state by one cycle; en=0 for
//    3 cycles -> state and out frozen, illegal=0.
//  5 Write entry {state=3} to next=6 in the same cycle as a step from 3 -> that
//    step goes to 5 (old entry); the next visit to 3 goes to 6.
//  6 Assert reset mid-sequence at state 5 between clk edges -> state=0, out=0,
//    err_cnt=0 immediately; the table is retained and the sequence restarts
//    0,1,3 after release.

Source files
------------

// File: rtl/rom_fsm_seq.sv
// Table-driven FSM: a writable table indexed by {state, in} supplies the next
// state and the output word. Invalid entries send the machine back to
// INIT_STATE and bump a saturating error counter.
module rom_fsm_seq #(
    parameter int unsigned STATE_W    = 3,
    parameter int unsigned IN_W       = 1,
    parameter int unsigned OUT_W      = 3,
    parameter int unsigned INIT_STATE = 0,
    parameter bit          REG_OUT    = 1'b0,
    parameter string       INIT_FILE  = ""
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic [(IN_W>0?IN_W:1)-1:0]    in_i,
    input  logic                          wr_en_i,
    input  logic [STATE_W+IN_W-1:0]       wr_addr_i,
    input  logic [STATE_W+OUT_W:0]        wr_data_i,
    output logic [OUT_W-1:0]              out_o,
    output logic [STATE_W-1:0]            state_o,
    output logic                          illegal_o,
    output logic [7:0]                    err_cnt_o
);

    localparam int unsigned AddrW = STATE_W + IN_W;
    localparam int unsigned EntW  = 1 + STATE_W + OUT_W;
    localparam int unsigned Depth = 1 << AddrW;
    localparam logic [STATE_W-1:0] InitSt = STATE_W'(INIT_STATE);

    logic [EntW-1:0]    table_q [Depth];
    logic [AddrW-1:0]   rd_addr;
    logic [EntW-1:0]    entry;
    logic               ent_valid;
    logic [STATE_W-1:0] ent_next;
    logic [OUT_W-1:0]   ent_out;

    logic [STATE_W-1:0] state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [7:0]         err_q, err_d;

    // With no input bits the table is indexed by state alone.
    if (IN_W == 0) begin : g_no_in
        logic unused_in;
        assign unused_in = ^in_i;
        assign rd_addr   = state_q;
    end else begin : g_in
        assign rd_addr = {state_q, in_i};
    end

    // Table write port; not reset, so contents survive reset assertion.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            table_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Asynchronous read: a same-edge write is seen only from the next cycle.
    assign entry     = table_q[rd_addr];
    assign ent_valid = entry[EntW-1];
    assign ent_next  = entry[OUT_W +: STATE_W];
    assign ent_out   = ent_valid ? entry[OUT_W-1:0] : '0;

    // Next-state, illegal pulse and saturating error count.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        err_d     = err_q;
        if (en_i) begin
            if (ent_valid) begin
                state_d = ent_next;
            end else begin
                state_d   = InitSt;
                illegal_d = 1'b1;
                err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= InitSt;
            illegal_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [OUT_W-1:0] out_q;
        // Registered output updates only on a step, aligned with the new state.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_q <= '0;
            end else if (en_i) begin
                out_q <= ent_out;
            end
        end
        assign out_o = out_q;
    end else begin : g_mealy_out
        assign out_o = ent_out;
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_rom_fsm_seq.sv
// Directed bench for rom_fsm_seq: three instances cover the degenerate-index
// Mealy table, an input-dependent toggle FSM and the registered-output mode.
module tb_rom_fsm_seq;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: STATE_W=3, IN_W=0, Mealy.
    logic       rst_a, en_a, wr_en_a, ill_a;
    logic [0:0] in_a;
    logic [2:0] wr_addr_a, out_a, state_a;
    logic [6:0] wr_data_a;
    logic [7:0] err_a;

    rom_fsm_seq #(.STATE_W(3), .IN_W(0), .OUT_W(3), .INIT_STATE(0), .REG_OUT(1'b0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_a), .en_i(en_a), .in_i(in_a), .wr_en_i(wr_en_a),
        .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a), .out_o(out_a), .state_o(state_a),
        .illegal_o(ill_a), .err_cnt_o(err_a)
    );

    // Instance B: 2-state toggle, STATE_W=1, IN_W=1, OUT_W=1, Mealy.
    logic       rst_bc, en_b, wr_en_b, ill_b;
    logic [0:0] in_b, out_b, state_b;
    logic [1:0] wr_addr_b;
    logic [2:0] wr_data_b;
    logic [7:0] err_b;

    rom_fsm_seq #(.STATE_W(1), .IN_W(1), .OUT_W(1), .INIT_STATE(0), .REG_OUT(1'b0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_bc), .en_i(en_b), .in_i(in_b), .wr_en_i(wr_en_b),
        .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b), .out_o(out_b), .state_o(state_b),
        .illegal_o(ill_b), .err_cnt_o(err_b)
    );

    // Instance C: scenario-1 table with registered output.
    logic       en_c, ill_c;
    logic [0:0] in_c;
    logic [2:0] out_c, state_c;
    logic [7:0] err_c;

    rom_fsm_seq #(.STATE_W(3), .IN_W(0), .OUT_W(3), .INIT_STATE(0), .REG_OUT(1'b1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_bc), .en_i(en_c), .in_i(in_c), .wr_en_i(wr_en_a),
        .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a), .out_o(out_c), .state_o(state_c),
        .illegal_o(ill_c), .err_cnt_o(err_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ent3(input logic v, input logic [2:0] n, input logic [2:0] o);
        return {v, n, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes reach both A and C, which share the write port.
    task automatic prog_ac(input logic [2:0] addr, input logic [6:0] data);
        wr_en_a   = 1'b1;
        wr_addr_a = addr;
        wr_data_a = data;
        tick();
        wr_en_a   = 1'b0;
    endtask

    task automatic prog_b(input logic [1:0] addr, input logic [2:0] data);
        wr_en_b   = 1'b1;
        wr_addr_b = addr;
        wr_data_b = data;
        tick();
        wr_en_b   = 1'b0;
    endtask

    initial begin
        logic [2:0] seq1 [6];
        logic [2:0] seq5 [6];
        seq1 = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd0};
        seq5 = '{3'd7, 3'd2, 3'd0, 3'd1, 3'd3, 3'd6};

        rst_a = 1'b0; rst_bc = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        tick();

        // Program every entry while reset is held.
        prog_ac(3'd0, ent3(1'b1, 3'd1, 3'd0));
        prog_ac(3'd1, ent3(1'b1, 3'd3, 3'd1));
        prog_ac(3'd2, ent3(1'b1, 3'd0, 3'd2));
        prog_ac(3'd3, ent3(1'b1, 3'd5, 3'd3));
        prog_ac(3'd4, 7'h00);
        prog_ac(3'd5, ent3(1'b1, 3'd7, 3'd5));
        prog_ac(3'd6, 7'h00);
        prog_ac(3'd7, ent3(1'b1, 3'd2, 3'd7));
        prog_b(2'b00, 3'b100);
        prog_b(2'b01, 3'b111);
        prog_b(2'b10, 3'b110);
        prog_b(2'b11, 3'b101);

        check_eq("rst_state", 32'(state_a), 32'd0);
        check_eq("rst_out", 32'(out_a), 32'd0);
        check_eq("rst_illegal", 32'(ill_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        check_eq("rst_out_reg", 32'(out_c), 32'd0);
        rst_a = 1'b1; rst_bc = 1'b1;

        // Scenario 1: fixed sequence with Mealy output equal to state.
        en_a = 1'b1;
        foreach (seq1[i]) begin
            tick();
            check_eq($sformatf("s1_state%0d", i), 32'(state_a), 32'(seq1[i]));
            check_eq($sformatf("s1_out%0d", i), 32'(out_a), 32'(seq1[i]));
        end
        en_a = 1'b0;

        // Scenario 3: state 0 -> 4 (invalid), recovery and saturation.
        prog_ac(3'd0, ent3(1'b1, 3'd4, 3'd0));
        check_eq("s3_hold", 32'(state_a), 32'd0);
        en_a = 1'b1;
        tick();
        check_eq("s3_in4", 32'(state_a), 32'd4);
        check_eq("s3_out4", 32'(out_a), 32'd0);
        check_eq("s3_ill_pre", 32'(ill_a), 32'd0);
        tick();
        check_eq("s3_recover", 32'(state_a), 32'd0);
        check_eq("s3_ill_pulse", 32'(ill_a), 32'd1);
        check_eq("s3_err1", 32'(err_a), 32'd1);
        tick();
        check_eq("s3_ill_drop", 32'(ill_a), 32'd0);
        check_eq("s3_err_hold", 32'(err_a), 32'd1);
        tick();
        check_eq("s3_err2", 32'(err_a), 32'd2);
        for (int k = 0; k < 298; k++) begin
            tick();
            tick();
        end
        check_eq("s3_err_sat", 32'(err_a), 32'd255);
        check_eq("s3_state_end", 32'(state_a), 32'd0);
        en_a = 1'b0;
        tick();
        check_eq("s3_ill_en0", 32'(ill_a), 32'd0);
        prog_ac(3'd0, ent3(1'b1, 3'd1, 3'd0));

        // Scenario 5: rewrite entry 3 on the same edge as the step out of 3.
        en_a = 1'b1;
        tick();
        tick();
        check_eq("s5_at3", 32'(state_a), 32'd3);
        wr_en_a = 1'b1; wr_addr_a = 3'd3; wr_data_a = ent3(1'b1, 3'd6, 3'd3);
        tick();
        wr_en_a = 1'b0;
        check_eq("s5_old_entry", 32'(state_a), 32'd5);
        foreach (seq5[i]) begin
            tick();
            check_eq($sformatf("s5_state%0d", i), 32'(state_a), 32'(seq5[i]));
        end
        check_eq("s5_out6", 32'(out_a), 32'd0);
        en_a = 1'b0;
        prog_ac(3'd3, ent3(1'b1, 3'd5, 3'd3));

        // Scenario 6: async reset at state 5, table kept.
        en_a = 1'b1;
        tick();
        check_eq("s6_ill", 32'(ill_a), 32'd1);
        check_eq("s6_err_sat", 32'(err_a), 32'd255);
        tick();
        tick();
        tick();
        check_eq("s6_at5", 32'(state_a), 32'd5);
        #2 rst_a = 1'b0;
        #1;
        check_eq("s6_rst_state", 32'(state_a), 32'd0);
        check_eq("s6_rst_out", 32'(out_a), 32'd0);
        check_eq("s6_rst_err", 32'(err_a), 32'd0);
        tick();
        check_eq("s6_rst_hold", 32'(state_a), 32'd0);
        rst_a = 1'b1;
        check_eq("s6_restart0", 32'(state_a), 32'd0);
        tick();
        check_eq("s6_restart1", 32'(state_a), 32'd1);
        tick();
        check_eq("s6_restart3", 32'(state_a), 32'd3);
        en_a = 1'b0;

        // Scenario 2: toggle FSM, out follows in combinationally.
        check_eq("s2_init", 32'(state_b), 32'd0);
        check_eq("s2_out0", 32'(out_b), 32'd0);
        in_b = 1'b1;
        #1;
        check_eq("s2_out_en0", 32'(out_b), 32'd1);
        en_b = 1'b1;
        tick();
        check_eq("s2_st_a", 32'(state_b), 32'd1);
        check_eq("s2_out_a", 32'(out_b), 32'd1);
        tick();
        check_eq("s2_st_b", 32'(state_b), 32'd0);
        in_b = 1'b0;
        #1;
        check_eq("s2_out_c", 32'(out_b), 32'd0);
        tick();
        check_eq("s2_st_c", 32'(state_b), 32'd0);
        in_b = 1'b1;
        #1;
        check_eq("s2_out_d", 32'(out_b), 32'd1);
        tick();
        check_eq("s2_st_d", 32'(state_b), 32'd1);
        en_b = 1'b0;

        // Scenario 4: registered output lags state by one step.
        check_eq("s4_init_out", 32'(out_c), 32'd0);
        en_c = 1'b1;
        tick();
        check_eq("s4_st1", 32'(state_c), 32'd1);
        check_eq("s4_out1", 32'(out_c), 32'd0);
        tick();
        check_eq("s4_st3", 32'(state_c), 32'd3);
        check_eq("s4_out3", 32'(out_c), 32'd1);
        tick();
        check_eq("s4_st5", 32'(state_c), 32'd5);
        check_eq("s4_out5", 32'(out_c), 32'd3);
        en_c = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("s4_frz_st%0d", k), 32'(state_c), 32'd5);
            check_eq($sformatf("s4_frz_out%0d", k), 32'(out_c), 32'd3);
            check_eq($sformatf("s4_frz_ill%0d", k), 32'(ill_c), 32'd0);
        end
        en_c = 1'b1;
        tick();
        check_eq("s4_st7", 32'(state_c), 32'd7);
        check_eq("s4_out7", 32'(out_c), 32'd5);
        en_c = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
